beehive_wormhole_out_arb: RTL

- Output-port arbiter for the dynamic NoC router; the stage directly upstream of the output crossbar 8:1 data mux.
- Arbitrates among up to 8 input ports using round-robin priority.
- Holds the winning port for a whole wormhole packet (head flit plus length-field body flits).
- Drives the 3-bit mux select, output valid, and per-input dequeue strobes.

---
 rtl/beehive_noc_pkg.sv | 21 ++
 rtl/beehive_rr_pick8.sv | 27 ++
 rtl/beehive_wormhole_out_arb.sv | 102 ++++++++++
 3 files changed

// File: rtl/beehive_noc_pkg.sv
// rtl/beehive_noc_pkg.sv - shared NoC router constants, header field positions and arbiter state type
package beehive_noc_pkg;

  // Arbitrated inputs per output port; sel is SEL_W bits wide
  localparam int NPORT = 8;
  localparam int SEL_W = 3;

  // Default width of the head-flit payload-length field (counts body flits)
  localparam int LEN_W = 8;

  // Position of the length field inside a head flit, for extracting req_len at the router top
  localparam int HDR_LEN_LSB = 0;
  localparam int HDR_LEN_MSB = HDR_LEN_LSB + LEN_W - 1;

  // Output-port arbiter states
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/beehive_rr_pick8.sv
// rtl/beehive_rr_pick8.sv - combinational round-robin picker over 8 requests
module beehive_rr_pick8
  import beehive_noc_pkg::*;
(
  input  logic [NPORT-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Scan from ptr+8 (== ptr, lowest priority) down to ptr+1 so the
  // nearest set bit above ptr is the last to overwrite idx.
  always_comb begin
    found = |req;
    idx   = '0;
    cand  = '0;
    for (int k = NPORT; k >= 1; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/beehive_wormhole_out_arb.sv
// rtl/beehive_wormhole_out_arb.sv - round-robin wormhole output-port arbiter driving the crossbar select
module beehive_wormhole_out_arb #(
  parameter int LEN_W = beehive_noc_pkg::LEN_W,
  parameter int NPORT = beehive_noc_pkg::NPORT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NPORT-1:0]       req_val,
  input  logic [NPORT*LEN_W-1:0] req_len,
  input  logic                   out_rdy,
  output logic                   out_val,
  output logic [2:0]             sel,
  output logic [NPORT-1:0]       grant,
  output logic                   busy
);

  import beehive_noc_pkg::*;

  localparam logic [LEN_W:0] REM_ONE = {{LEN_W{1'b0}}, 1'b1};

  arb_state_e     state;
  arb_state_e     state_n;
  logic [2:0]     rr_ptr;
  logic [LEN_W:0] remaining;
  logic           found;
  logic [2:0]     win;
  logic [LEN_W-1:0] win_len;
  logic           xfer;

  beehive_rr_pick8 u_pick (
    .req   (req_val),
    .ptr   (rr_ptr),
    .found (found),
    .idx   (win)
  );

  // Length field of the arbitration winner; only consumed on the IDLE->BUSY edge
  assign win_len = req_len[int'(win)*LEN_W +: LEN_W];

  assign busy = (state == BUSY);

  // Next state and per-cycle handshake outputs; the lock is only released by the tail transfer
  always_comb begin
    state_n = state;
    out_val = 1'b0;
    grant   = '0;
    xfer    = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_n = BUSY;
        end
      end
      BUSY: begin
        out_val    = req_val[sel];
        xfer       = req_val[sel] && out_rdy;
        grant[sel] = xfer;
        if (xfer && (remaining == REM_ONE)) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Select, beat counter and round-robin pointer; sel only moves when a packet is won
  always_ff @(posedge clk) begin
    if (reset) begin
      sel       <= 3'd0;
      rr_ptr    <= 3'd7;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            sel       <= win;
            remaining <= {1'b0, win_len} + REM_ONE;
          end
        end
        BUSY: begin
          if (xfer) begin
            remaining <= remaining - REM_ONE;
            if (remaining == REM_ONE) begin
              rr_ptr <= sel;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
